// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one fixed-latency single-port memory between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention; otherwise the data port has fixed priority.
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_W/8-1:0]   dm_sel,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_sel,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_req
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                owner_reg, owner_next;
    logic                mem_ce_reg, mem_ce_next;
    logic                mem_we_reg, mem_we_next;
    logic [SEL_W-1:0]    mem_sel_reg, mem_sel_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0]   dm_rdata_reg, dm_rdata_next;
    logic                if_ack_reg, if_ack_next;
    logic                dm_ack_reg, dm_ack_next;
    logic                grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant_reg: 0 = IF, 1 = DM; the port not served last wins a tie
    logic last_grant_reg, last_grant_next;

    always_comb begin
        if (if_req && dm_req) begin
            grant_dm = ~last_grant_reg;
        end else begin
            grant_dm = dm_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_reg <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            owner_reg     <= 1'b0;
            mem_ce_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_sel_reg   <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_ack_reg    <= 1'b0;
            dm_ack_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            owner_reg     <= owner_next;
            mem_ce_reg    <= mem_ce_next;
            mem_we_reg    <= mem_we_next;
            mem_sel_reg   <= mem_sel_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            if_ack_reg    <= if_ack_next;
            dm_ack_reg    <= dm_ack_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        owner_next     = owner_reg;
        mem_ce_next    = mem_ce_reg;
        mem_we_next    = mem_we_reg;
        mem_sel_next   = mem_sel_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        if_ack_next    = 1'b0;
        dm_ack_next    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_next = last_grant_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_next  = BUSY;
                    cnt_next    = CNT_LOAD;
                    owner_next  = grant_dm;
                    mem_ce_next = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_next = grant_dm;
`endif
                    if (grant_dm) begin
                        mem_we_next    = dm_we;
                        mem_sel_next   = dm_sel;
                        mem_addr_next  = dm_addr;
                        mem_wdata_next = dm_wdata;
                    end else begin
                        mem_we_next    = 1'b0;
                        mem_sel_next   = '1;
                        mem_addr_next  = if_addr;
                        mem_wdata_next = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    // mem_rdata is valid only in this final wait cycle
                    if (!mem_we_reg) begin
                        if (owner_reg) begin
                            dm_rdata_next = mem_rdata;
                        end else begin
                            if_rdata_next = mem_rdata;
                        end
                    end
                    mem_ce_next  = 1'b0;
                    mem_we_next  = 1'b0;
                    mem_sel_next = '0;
                    if_ack_next  = ~owner_reg;
                    dm_ack_next  = owner_reg;
                    state_next   = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign if_ack    = if_ack_reg;
    assign dm_ack    = dm_ack_reg;
    assign mem_ce    = mem_ce_reg;
    assign mem_we    = mem_we_reg;
    assign mem_sel   = mem_sel_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign stall_req = (if_req & ~if_ack_reg) | (dm_req & ~dm_ack_reg);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus reset, contention
// and WAIT_CYCLES=1 sequences on a second instance.
module tb_mem_bus_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_sel;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_ce, mem_we, stall_req;
    logic [3:0]  mem_sel;

    logic        w1_if_req;
    logic [31:0] w1_if_rdata, w1_dm_rdata, w1_mem_addr, w1_mem_wdata, w1_mem_rdata;
    logic        w1_if_ack, w1_dm_ack, w1_mem_ce, w1_mem_we, w1_stall_req;
    logic [3:0]  w1_mem_sel;

    logic [31:0] bench_mem [16];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign mem_rdata    = bench_mem[mem_addr[5:2]];
    assign w1_mem_rdata = 32'hCAFE_0001;

    mem_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_req(stall_req)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(w1_if_req), .if_addr(32'h0000_0020), .if_rdata(w1_if_rdata), .if_ack(w1_if_ack),
        .dm_req(1'b0), .dm_we(1'b0), .dm_sel(4'h0), .dm_addr(32'h0),
        .dm_wdata(32'h0), .dm_rdata(w1_dm_rdata), .dm_ack(w1_dm_ack),
        .mem_ce(w1_mem_ce), .mem_we(w1_mem_we), .mem_sel(w1_mem_sel), .mem_addr(w1_mem_addr),
        .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata), .stall_req(w1_stall_req)
    );

    typedef struct {
        string       name;
        bit          is_dm;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge with the DUT idle
    task automatic run_txn(input vec_t v);
        int  k;
        int  ce_cnt;
        bit  done;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_sel = v.sel; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        k = 0; ce_cnt = 0; done = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (mem_ce) ce_cnt++;
            if (k == 1) begin
                chk({v.name, "_mem_we"},  {31'b0, mem_we}, {31'b0, v.is_dm ? v.we : 1'b0});
                chk({v.name, "_mem_sel"}, {28'b0, mem_sel}, {28'b0, v.is_dm ? v.sel : 4'hF});
                chk({v.name, "_mem_addr"}, mem_addr, v.addr);
                if (v.is_dm) chk({v.name, "_mem_wdata"}, mem_wdata, v.wdata);
                chk({v.name, "_stall_busy"}, {31'b0, stall_req}, 32'd1);
            end
            if (v.is_dm ? dm_ack : if_ack) done = 1'b1;
        end
        chk({v.name, "_ack_seen"}, {31'b0, done}, 32'd1);
        chk({v.name, "_latency"}, k, W + 1);
        chk({v.name, "_ce_cycles"}, ce_cnt, W);
        chk({v.name, "_stall_at_ack"}, {31'b0, stall_req}, 32'd0);
        chk({v.name, "_other_ack"}, {31'b0, v.is_dm ? if_ack : dm_ack}, 32'd0);
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        chk({v.name, "_ack_pulse"}, {30'b0, if_ack, dm_ack}, 32'd0);
        chk({v.name, "_if_rdata"}, if_rdata, v.exp_if_rdata);
        chk({v.name, "_dm_rdata"}, dm_rdata, v.exp_dm_rdata);
    endtask

    initial begin
        vec_t vecs [5];
        vec_t fresh;
        int   k;
        bit   got;
        bit   exp_dm;

        foreach (bench_mem[i]) bench_mem[i] = 32'h0;
        bench_mem[1] = 32'h3401_1100;
        bench_mem[4] = 32'hDEAD_BEEF;
        bench_mem[5] = 32'h1234_5678;

        vecs[0] = '{"fetch4",  1'b0, 1'b0, 4'hF, 32'h04, 32'h0,         32'h3401_1100, 32'h0};
        vecs[1] = '{"store10", 1'b1, 1'b1, 4'h3, 32'h10, 32'hA5A5_1234, 32'h3401_1100, 32'h0};
        vecs[2] = '{"load10",  1'b1, 1'b0, 4'hF, 32'h10, 32'h0,         32'h3401_1100, 32'hDEAD_BEEF};
        vecs[3] = '{"fetch14", 1'b0, 1'b0, 4'hF, 32'h14, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};
        vecs[4] = '{"store08", 1'b1, 1'b1, 4'h8, 32'h08, 32'h0BAD_F00D, 32'h1234_5678, 32'hDEAD_BEEF};

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_sel = '0;
        dm_addr = '0; dm_wdata = '0; w1_if_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mem_ce", {31'b0, mem_ce}, 32'd0);
        chk("reset_mem_sel", {28'b0, mem_sel}, 32'd0);
        chk("reset_acks", {30'b0, if_ack, dm_ack}, 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_dm_rdata", dm_rdata, 32'd0);
        chk("reset_stall", {31'b0, stall_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
            $display("txn %s done", vecs[i].name);
        end

        // Reset during BUSY
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("rst_pre_ce", {31'b0, mem_ce}, 32'd1);
        rst = 1'b0; if_req = 1'b0;
        #1;
        chk("rst_mid_ce", {31'b0, mem_ce}, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_sel", {28'b0, mem_sel}, 32'd0);
        chk("rst_mid_if_rdata", if_rdata, 32'd0);
        chk("rst_mid_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stray_ack", {30'b0, if_ack, dm_ack}, 32'd0);
            chk("rst_idle_ce", {31'b0, mem_ce}, 32'd0);
        end
        fresh = '{"post_rst", 1'b0, 1'b0, 4'hF, 32'h04, 32'h0, 32'h3401_1100, 32'h0};
        run_txn(fresh);
        $display("txn reset-mid-access done");

        // Contention: both ports held through four completions
        if_req = 1'b1; if_addr = 32'h04;
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h10;
        for (int n = 0; n < 4; n++) begin
            k = 0; got = 1'b0;
            while (!got && k < 20) begin
                @(negedge clk);
                k++;
                if (if_ack || dm_ack) got = 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            exp_dm = (n % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            chk("cont_ack_seen", {31'b0, got}, 32'd1);
            chk("cont_latency", k, (n == 0) ? W + 1 : W + 2);
            chk("cont_grant", {30'b0, if_ack, dm_ack}, {30'b0, ~exp_dm, exp_dm});
            $display("contention txn %0d granted %s", n, dm_ack ? "DM" : "IF");
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        chk("cont_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        chk("cont_if_rdata", if_rdata, 32'h3401_1100);

        // WAIT_CYCLES=1: back-to-back fetches every 3 cycles
        w1_if_req = 1'b1;
        for (int k1 = 1; k1 <= 12; k1++) begin
            @(negedge clk);
            chk("w1_mem_ce", {31'b0, w1_mem_ce}, {31'b0, (k1 % 3) == 1});
            chk("w1_if_ack", {31'b0, w1_if_ack}, {31'b0, (k1 % 3) == 2});
        end
        w1_if_req = 1'b0;
        @(negedge clk);
        chk("w1_if_rdata", w1_if_rdata, 32'hCAFE_0001);
        $display("txn w1 back-to-back fetches done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-port, fixed-latency memory between the CPU core's instruction-fetch port and its load/store (data) port inside the minimal SOPC. It grants one requester at a time, drives the shared memory bus from registers, counts the memory's wait states and returns read data with a one-cycle acknowledge. It also raises a stall request toward the pipeline control unit while any request is outstanding.

## Interface
- WAIT_CYCLES, 2: memory access latency in cycles (legal range 1..15).
- ADDR_W, 32: address width.
- DATA_W, 32: data width (byte-select width = DATA_W/8).

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch request, level, held until if_ack.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_rdata  out  DATA_W  fetched word, valid from if_ack onward.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request, level, held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_sel  in  DATA_W/8  byte enables.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid from dm_ack onward.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_ce / mem_we  out  1  shared-memory chip enable / write enable.
- mem_sel  out  DATA_W/8  shared-memory byte enables.
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  shared-memory address and write data.
- mem_rdata  in  DATA_W  shared-memory read data, valid in the last BUSY cycle.
- stall_req  out  1  pipeline stall request.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - With no request, stay in IDLE.
  - With any request, select a winner and register the mem_* outputs from the winner: mem_ce=1, plus mem_we/mem_sel/mem_wdata from dm_*.
  - For a fetch: mem_we=0 and mem_sel all ones.
  - Load the counter with WAIT_CYCLES-1, latch owner (0 = IF, 1 = DM) and go to BUSY.
- BUSY
  - mem_* outputs stay constant.
  - While the counter is nonzero, decrement it.
  - When the counter is 0:
    - For a read, capture mem_rdata into the owner's rdata register.
    - Clear mem_ce/mem_we/mem_sel, set the owner's ack and go to RESP.
- RESP
  - The owner's ack is high for exactly this cycle.
  - Next state is always IDLE; this gives one turnaround cycle per transaction.
- Stores do not modify dm_rdata. Fetches modify only if_rdata.
- stall_req is combinational: (if_req & ~if_ack) | (dm_req & ~dm_ack).
- Priority when both requests are high in IDLE: dm wins (default; see Configuration).
- A request that drops while it is not granted is simply ignored. A request that drops during BUSY does not abort the access; the ack still issues.
- Reset values: state IDLE, counter 0, all mem_* 0, if_ack/dm_ack 0, if_rdata/dm_rdata 0, owner 0, last-grant register = IF.
- Reset asserted mid-transaction aborts it immediately. No ack is issued and outputs return to their reset values asynchronously.

## Timing
- Request first sampled high in IDLE at edge t:
  - mem_ce high for cycles t+1 .. t+WAIT_CYCLES.
  - ack high in cycle t+WAIT_CYCLES+1.
  - FSM back in IDLE at t+WAIT_CYCLES+2.
- Throughput is one access per WAIT_CYCLES+2 cycles.
- The requester must deassert or change its request on the edge after seeing ack. A request still high in the following IDLE cycle is a new transaction.
- rdata is registered and stays stable until the same port's next read completes.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- When defined:
  - A 1-bit last-grant register (reset = IF) is updated on every grant.
  - When both ports request in IDLE, the port not granted last wins, so strict alternation occurs under contention.
- When undefined:
  - Fixed priority: dm always beats if.
  - The last-grant register is absent.

## Test plan
- Single fetch, WAIT_CYCLES=2: if_req=1, if_addr=0x0000_0004, memory returns 0x3401_1100 → mem_ce high 2 cycles with mem_we=0 and mem_sel=4'hF; if_ack pulses at cycle t+3; if_rdata=0x3401_1100; stall_req falls with if_ack.
- Store: dm_req=1, dm_we=1, dm_sel=4'b0011, dm_addr=0x10, dm_wdata=0xA5A5_1234 → mem_we=1, mem_sel=4'b0011, mem_wdata=0xA5A5_1234 for 2 cycles; dm_ack pulses once; dm_rdata unchanged.
- Contention without the macro: if_req and dm_req both held high through repeated completions → dm granted each time and if_ack never pulses while dm_req stays high.
- Contention with ARB_ROUND_ROBIN_EN: both held for 4 transactions → grant order DM, IF, DM, IF; each port sees exactly 2 acks.
- Reset mid-access: drop rst during BUSY → all outputs go to 0 immediately; after rst is released, no stray ack appears and a fresh request completes with normal latency.
- WAIT_CYCLES=1 boundary: back-to-back fetches → ack every 3 cycles; mem_ce high 1 cycle per access.
